// File: rtl/grn_sweep_ctrl_if.sv
// Controller-side bus of grn_sweep_ctrl: range FIFO, network control, result FIFO.
interface grn_sweep_ctrl_if #(
    parameter int NODES = 188,
    parameter int CNT_W = 29
);
    logic                     fifo_in_empty;
    logic [2*NODES-1:0]       fifo_in_data;
    logic                     end_data_in;
    logic                     fifo_in_re;
    logic [NODES-1:0]         s0;
    logic [NODES-1:0]         s1;
    logic                     reset_nos;
    logic                     start_s0;
    logic                     start_s1;
    logic [NODES-1:0]         init_state;
    logic                     fifo_out_full;
    logic                     fifo_out_empty;
    logic                     fifo_out_we;
    logic [NODES+2*CNT_W:0]   data_out;

    modport master (
        input  fifo_in_empty, fifo_in_data, end_data_in, s0, s1,
               fifo_out_full, fifo_out_empty,
        output fifo_in_re, reset_nos, start_s0, start_s1, init_state,
               fifo_out_we, data_out
    );

    modport slave (
        output fifo_in_empty, fifo_in_data, end_data_in, s0, s1,
               fifo_out_full, fifo_out_empty,
        input  fifo_in_re, reset_nos, start_s0, start_s1, init_state,
               fifo_out_we, data_out
    );
endinterface

// File: rtl/grn_sweep_ctrl.sv
// Sweeps ranges of initial network states, runs Floyd cycle detection on each
// and writes {timeout, period, meet_steps, init_state} per state.
module grn_sweep_ctrl #(
    parameter int          ID        = 0,
    parameter int          NODES     = 188,
    parameter int          CNT_W     = 29,
    parameter int unsigned MAX_STEPS = 32'd1 << 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    grn_sweep_ctrl_if.master bus
);
    if (ID < 0 || (64'(MAX_STEPS) >> CNT_W) != 64'd0) begin : g_bad_params
        $error("grn_sweep_ctrl: ID must be >= 0 and MAX_STEPS < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, RUN, PERIOD, WRITE, DONE
    } state_t;

    state_t           state, nxt;
    logic [NODES-1:0] cur_q, end_q;
    logic [CNT_W-1:0] cnt_q, per_q, meet_q, period_q;
    logic             timeout_q;
    logic             match;

    logic [NODES-1:0] in_begin, in_end;
    assign {in_end, in_begin} = bus.fifo_in_data;
    assign match              = (bus.s0 == bus.s1);

    assign bus.init_state = cur_q;
    assign bus.data_out   = {timeout_q, period_q, meet_q, cur_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt             = state;
        bus.fifo_in_re  = 1'b0;
        bus.reset_nos   = 1'b0;
        bus.start_s0    = 1'b0;
        bus.start_s1    = 1'b0;
        bus.fifo_out_we = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: if (start) nxt = FETCH;
            FETCH: begin
                if (!bus.fifo_in_empty) begin
                    bus.fifo_in_re = 1'b1;
                    nxt            = LOAD;
                end else if (bus.end_data_in && bus.fifo_out_empty) begin
                    nxt = DONE;
                end
            end
            LOAD: begin
                bus.reset_nos = 1'b1;
                nxt           = RUN;
            end
            // cnt==0 is the freshly loaded state where s0==s1 trivially.
            RUN: begin
                if (cnt_q != '0 && match) nxt = PERIOD;
                else if (cnt_q == MAX_C)  nxt = WRITE;
                else begin
                    bus.start_s0 = 1'b1;
                    bus.start_s1 = 1'b1;
                end
            end
            PERIOD: begin
                if (per_q != '0 && match) nxt = WRITE;
                else if (per_q == MAX_C)  nxt = WRITE;
                else                      bus.start_s0 = 1'b1;
            end
            WRITE: begin
                if (!bus.fifo_out_full) begin
                    bus.fifo_out_we = 1'b1;
                    nxt             = (cur_q >= end_q) ? FETCH : LOAD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) nxt = FETCH;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q     <= '0;
            end_q     <= '0;
            cnt_q     <= '0;
            per_q     <= '0;
            meet_q    <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!bus.fifo_in_empty) begin
                        cur_q <= in_begin;
                        end_q <= in_end;
                    end
                end
                LOAD: begin
                    cnt_q <= '0;
                    per_q <= '0;
                end
                RUN: begin
                    if (cnt_q != '0 && match) begin
                        meet_q <= cnt_q;
                    end else if (cnt_q == MAX_C) begin
                        timeout_q <= 1'b1;
                        period_q  <= '0;
                        meet_q    <= MAX_C;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PERIOD: begin
                    if (per_q != '0 && match) begin
                        period_q  <= per_q;
                        timeout_q <= 1'b0;
                    end else if (per_q == MAX_C) begin
                        timeout_q <= 1'b1;
                        period_q  <= '0;
                    end else begin
                        per_q <= per_q + CNT_W'(1);
                    end
                end
                // Advance only while below end, so end=all-ones never wraps.
                WRITE: begin
                    if (!bus.fifo_out_full && cur_q < end_q) cur_q <= cur_q + NODES'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_grn_sweep_ctrl.sv
// Directed bench for grn_sweep_ctrl with a small behavioural network and FIFO stubs.
module tb_grn_sweep_ctrl;
    localparam int NODES = 8;
    localparam int CNT_W = 8;
    localparam int MAXS  = 8;
    localparam int DW    = NODES + 2*CNT_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic done;

    grn_sweep_ctrl_if #(.NODES(NODES), .CNT_W(CNT_W)) bus ();

    grn_sweep_ctrl #(.ID(3), .NODES(NODES), .CNT_W(CNT_W), .MAX_STEPS(MAXS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int net_mode = 0;
    int re_cnt = 0;
    int excl_viol = 0;
    logic [DW-1:0] out_q[$];
    logic [NODES-1:0] s0_r, s1_r;

    // mode 0: identity, mode 1: 0x10..0x12 tail into 0x13<->0x14, mode 2: +1 (long cycle)
    function automatic logic [NODES-1:0] f_net(input logic [NODES-1:0] x, input int m);
        case (m)
            0:       return x;
            1:       return (x == 8'h14) ? 8'h13 : x + 8'd1;
            default: return x + 8'd1;
        endcase
    endfunction

    function automatic int floyd_meet(input logic [NODES-1:0] x0, input int m);
        logic [NODES-1:0] t, h;
        t = x0;
        h = x0;
        for (int i = 1; i <= MAXS; i++) begin
            t = f_net(t, m);
            h = f_net(f_net(h, m), m);
            if (t == h) return i;
        end
        return MAXS;
    endfunction

    always @(posedge clk) begin
        if (bus.reset_nos) begin
            s0_r <= bus.init_state;
            s1_r <= bus.init_state;
        end else begin
            if (bus.start_s0) s0_r <= f_net(s0_r, net_mode);
            if (bus.start_s1) s1_r <= f_net(f_net(s1_r, net_mode), net_mode);
        end
    end
    assign bus.s0 = s0_r;
    assign bus.s1 = s1_r;

    always @(posedge clk) begin
        if (bus.fifo_out_we) out_q.push_back(bus.data_out);
        if (bus.fifo_in_re) re_cnt++;
        if ((int'(bus.fifo_in_re) + int'(bus.fifo_out_we) + int'(bus.reset_nos)
             + int'(bus.start_s0 | bus.start_s1)) > 1 || (bus.start_s1 && !bus.start_s0))
            excl_viol++;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_range(input logic [NODES-1:0] b, input logic [NODES-1:0] e);
        int k;
        @(negedge clk);
        bus.fifo_in_data  = {e, b};
        bus.fifo_in_empty = 1'b0;
        #1;
        k = 0;
        while (!bus.fifo_in_re && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (bus.fifo_in_re !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_re: fifo_in_re=%b required 1 (range %h..%h)", bus.fifo_in_re, b, e);
        end
        @(posedge clk);
        #1;
        bus.fifo_in_empty = 1'b1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (out_q.size() < n) begin
            n_bad++;
            $display("FAIL write_wait: got %0d writes required %0d", out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.fifo_in_re, bus.reset_nos, bus.start_s0, bus.start_s1, bus.fifo_out_we, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b required 000000",
                     {bus.fifo_in_re, bus.reset_nos, bus.start_s0, bus.start_s1, bus.fifo_out_we, done});
        end
        n_cmp++;
        if (bus.data_out !== '0) begin
            n_bad++;
            $display("FAIL reset_data_out: got %h required 0", bus.data_out);
        end
        n_cmp++;
        if (bus.init_state !== '0) begin
            n_bad++;
            $display("FAIL reset_init_state: got %h required 0", bus.init_state);
        end
        rst = 1'b1;
        pulse_start();
    endtask

    task automatic test_fixed_point();
        net_mode = 0;
        out_q.delete();
        push_range(8'h5A, 8'h5A);
        wait_writes(1, 40);
        n_cmp++;
        if (out_q.size() < 1 || out_q[0] !== {1'b0, 8'd1, 8'd1, 8'h5A}) begin
            n_bad++;
            $display("FAIL fixed_point: got %h required %h", (out_q.size() > 0) ? out_q[0] : '0,
                     {1'b0, 8'd1, 8'd1, 8'h5A});
        end
    endtask

    task automatic test_attractor();
        logic [DW-1:0] exp;
        net_mode = 1;
        out_q.delete();
        exp = {1'b0, 8'd2, 8'(floyd_meet(8'h10, 1)), 8'h10};
        push_range(8'h10, 8'h10);
        wait_writes(1, 60);
        n_cmp++;
        if (out_q.size() < 1 || out_q[0] !== exp) begin
            n_bad++;
            $display("FAIL attractor: got %h required %h", (out_q.size() > 0) ? out_q[0] : '0, exp);
        end
    endtask

    task automatic test_range();
        int re0;
        net_mode = 0;
        out_q.delete();
        re0 = re_cnt;
        push_range(8'h05, 8'h07);
        wait_writes(3, 80);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_q.size() <= i || out_q[i] !== {1'b0, 8'd1, 8'd1, 8'(5 + i)}) begin
                n_bad++;
                $display("FAIL range_write%0d: got %h required %h", i,
                         (out_q.size() > i) ? out_q[i] : '0, {1'b0, 8'd1, 8'd1, 8'(5 + i)});
            end
        end
        n_cmp++;
        if (re_cnt - re0 !== 1) begin
            n_bad++;
            $display("FAIL range_re_count: got %0d required 1", re_cnt - re0);
        end
        push_range(8'h30, 8'h30);
        wait_writes(4, 40);
        n_cmp++;
        if (re_cnt - re0 !== 2) begin
            n_bad++;
            $display("FAIL range_next_re: got %0d required 2", re_cnt - re0);
        end
    endtask

    task automatic test_bounds();
        net_mode = 0;
        out_q.delete();
        push_range(8'h09, 8'h03);
        wait_writes(1, 40);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (out_q.size() !== 1 || out_q[0][NODES-1:0] !== 8'h09) begin
            n_bad++;
            $display("FAIL end_lt_begin: got %0d writes first init %h required 1 write init 09",
                     out_q.size(), (out_q.size() > 0) ? out_q[0][NODES-1:0] : 8'h00);
        end
        out_q.delete();
        push_range(8'hFE, 8'hFF);
        wait_writes(2, 60);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (out_q.size() !== 2 || out_q[0][NODES-1:0] !== 8'hFE || out_q[1][NODES-1:0] !== 8'hFF) begin
            n_bad++;
            $display("FAIL end_all_ones: got %0d writes required 2 (FE,FF)", out_q.size());
        end
    endtask

    task automatic test_timeout();
        net_mode = 2;
        out_q.delete();
        push_range(8'h03, 8'h03);
        wait_writes(1, 60);
        n_cmp++;
        if (out_q.size() < 1 || out_q[0] !== {1'b1, 8'd0, 8'd8, 8'h03}) begin
            n_bad++;
            $display("FAIL timeout: got %h required %h", (out_q.size() > 0) ? out_q[0] : '0,
                     {1'b1, 8'd0, 8'd8, 8'h03});
        end
    endtask

    task automatic test_backpressure();
        net_mode = 0;
        out_q.delete();
        bus.fifo_out_full = 1'b1;
        push_range(8'h21, 8'h21);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.fifo_out_we !== 1'b0 || bus.data_out !== {1'b0, 8'd1, 8'd1, 8'h21}) begin
                n_bad++;
                $display("FAIL full_hold%0d: we=%b data=%h required we=0 data=%h", i,
                         bus.fifo_out_we, bus.data_out, {1'b0, 8'd1, 8'd1, 8'h21});
            end
        end
        bus.fifo_out_full = 1'b0;
        #1;
        n_cmp++;
        if (bus.fifo_out_we !== 1'b1) begin
            n_bad++;
            $display("FAIL full_release_we: got %b required 1", bus.fifo_out_we);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.fifo_out_we !== 1'b0 || out_q.size() !== 1) begin
            n_bad++;
            $display("FAIL full_single_we: we=%b writes=%0d required we=0 writes=1",
                     bus.fifo_out_we, out_q.size());
        end
    endtask

    task automatic test_done();
        bus.fifo_out_empty = 1'b0;
        bus.end_data_in    = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_wait_out_empty: got %b required 0", done);
        end
        bus.fifo_out_empty = 1'b1;
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_early: got %b required 0", done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_rise: got %b required 1", done);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_held: got %b required 1", done);
        end
        start           = 1'b1;
        bus.end_data_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_clear: got %b required 0", done);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        // mid-RUN: long cycle network, several steps in
        net_mode = 2;
        out_q.delete();
        push_range(8'h40, 8'h40);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.start_s1 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_run_reached: start_s1=%b required 1", bus.start_s1);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fifo_in_re, bus.reset_nos, bus.start_s0, bus.start_s1, bus.fifo_out_we, done} !== 6'b0
            || bus.data_out !== '0 || bus.init_state !== '0) begin
            n_bad++;
            $display("FAIL mid_run_reset: strobes=%b data=%h init=%h required all 0",
                     {bus.fifo_in_re, bus.reset_nos, bus.start_s0, bus.start_s1, bus.fifo_out_we, done},
                     bus.data_out, bus.init_state);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (out_q.size() !== 0) begin
            n_bad++;
            $display("FAIL mid_run_no_write: got %0d writes required 0", out_q.size());
        end
        // mid-PERIOD: attractor network, wait for tortoise-only stepping
        pulse_start();
        net_mode = 1;
        push_range(8'h10, 8'h10);
        k = 0;
        while (!(bus.start_s0 && !bus.start_s1) && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!(bus.start_s0 === 1'b1 && bus.start_s1 === 1'b0)) begin
            n_bad++;
            $display("FAIL mid_period_reached: s0=%b s1=%b required 1 0", bus.start_s0, bus.start_s1);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fifo_in_re, bus.reset_nos, bus.start_s0, bus.start_s1, bus.fifo_out_we, done} !== 6'b0
            || bus.data_out !== '0 || bus.init_state !== '0) begin
            n_bad++;
            $display("FAIL mid_period_reset: strobes=%b data=%h init=%h required all 0",
                     {bus.fifo_in_re, bus.reset_nos, bus.start_s0, bus.start_s1, bus.fifo_out_we, done},
                     bus.data_out, bus.init_state);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (out_q.size() !== 0) begin
            n_bad++;
            $display("FAIL mid_period_no_write: got %0d writes required 0", out_q.size());
        end
    endtask

    task automatic test_exclusive();
        n_cmp++;
        if (excl_viol !== 0) begin
            n_bad++;
            $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", excl_viol);
        end
    endtask

    initial begin
        bus.fifo_in_empty  = 1'b1;
        bus.fifo_in_data   = '0;
        bus.end_data_in    = 1'b0;
        bus.fifo_out_full  = 1'b0;
        bus.fifo_out_empty = 1'b1;
        test_reset();
        test_fixed_point();
        test_attractor();
        test_range();
        test_bounds();
        test_timeout();
        test_backpressure();
        test_done();
        test_reset_mid();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/grn_sweep_ctrl.md
GRN_SWEEP_CTRL -- requirements
Module: grn_sweep_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ID, 0, instance identifier.
- NODES, 188, network state width.
- CNT_W, 29, step/period counter width.
- MAX_STEPS, 2^28, step limit before timeout; SHALL be less than 2^CNT_W.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, pulse that arms the sweep.
- fifo_in_empty, in, 1, input FIFO empty.
- fifo_in_data, in, 2*NODES, {end_state, begin_state}; show-ahead, valid while !fifo_in_empty.
- end_data_in, in, 1, no further ranges will arrive.
- fifo_in_re, out, 1, consume the head word.
- s0, in, NODES, tortoise state from the network.
- s1, in, NODES, hare state from the network.
- reset_nos, out, 1, load s0=s1=init_state at the next edge.
- start_s0, out, 1, s0<=f(s0) at the next edge.
- start_s1, out, 1, s1<=f(f(s1)) at the next edge.
- init_state, out, NODES, current initial state.
- fifo_out_full, in, 1, output FIFO full.
- fifo_out_empty, in, 1, output FIFO empty.
- fifo_out_we, out, 1, write strobe.
- data_out, out, NODES+2*CNT_W+1, {timeout, period, meet_steps, init_state}.
- done, out, 1, sweep complete.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, LOAD, RUN, PERIOD, WRITE, DONE.
REQ-004 IDLE->FETCH on start; start SHALL be ignored in every state except IDLE and DONE.
REQ-005 FETCH, !fifo_in_empty: fifo_in_re=1 for exactly one cycle; begin/end latched that cycle; cur<=begin; ->LOAD.
REQ-006 FETCH, fifo_in_empty & end_data_in & fifo_out_empty: ->DONE; otherwise wait in FETCH.
REQ-007 LOAD: reset_nos=1, init_state=cur, cnt<=0, per<=0; ->RUN next cycle.
REQ-008 RUN, cnt!=0 & s0==s1: no start_s*; meet_steps<=cnt; ->PERIOD.
REQ-009 RUN, cnt==MAX_STEPS without a match: timeout<=1, period<=0, meet_steps<=MAX_STEPS; ->WRITE.
REQ-010 RUN, otherwise: start_s0=start_s1=1; cnt<=cnt+1; the match test with cnt==0 SHALL be suppressed.
REQ-011 PERIOD, per!=0 & s0==s1: period<=per, timeout<=0; ->WRITE.
REQ-012 PERIOD, otherwise: start_s0=1 only (s1 frozen); per<=per+1; per reaching MAX_STEPS SHALL set timeout=1, period=0, ->WRITE.
REQ-013 WRITE: hold until !fifo_out_full, then fifo_out_we=1 for one cycle with data_out stable.
REQ-014 After the write, cur>=end (unsigned) ->FETCH; otherwise cur<=cur+1 and ->LOAD. end<begin SHALL process begin only; end=all-ones SHALL terminate without wrap.
REQ-015 init_state SHALL equal cur from LOAD through WRITE.
REQ-016 DONE: done=1, held. start in DONE SHALL clear done and ->FETCH.
REQ-017 reset_nos, start_s0, start_s1, fifo_in_re and fifo_out_we SHALL never be asserted in the same cycle as one another, except start_s0 with start_s1.
REQ-018 Per-state latency: 1 cycle for LOAD; meet_steps+1 cycles for RUN; period+1 cycles for PERIOD; at least 1 cycle for WRITE.

Reset
REQ-019 rst low SHALL asynchronously force IDLE and clear every output, counter and latch to 0.
REQ-020 rst asserted mid-RUN SHALL discard the range in progress; no partial fifo_out_we SHALL occur.

Verification
REQ-021 Fixed point f(x0)=x0, range {x0,x0} -> one write {0,1,1,x0}, then FETCH.
REQ-022 2-cycle attractor entered after 3 transient steps -> period=2 and meet_steps equal to the Floyd meeting index (model-checked), timeout=0.
REQ-023 Range begin=5, end=7 -> three writes with init_state 5,6,7 in order, then a single fifo_in_re for the next range.
REQ-024 MAX_STEPS=8 with a network whose cycle exceeds 8 -> write {1,0,8,init}.
REQ-025 fifo_out_full held for 10 cycles in WRITE -> no we and data_out stable; one we within 1 cycle of deassertion.
REQ-026 end_data_in=1, fifo_in_empty=1, fifo_out_empty=0 -> stays in FETCH; done rises 1 cycle after fifo_out_empty=1; start then clears done. rst pulsed mid-PERIOD -> all outputs 0 the same cycle.
